// File: rtl/fd_decode_if.sv
// fd_decode_if: bundle between fetch, the FD latch and the DX latch.
// master drives fetch/execute feedback; slave is the decode stage.
interface fd_decode_if;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        flush;
  logic        md_busy;
  logic [4:0]  dx_opcode;
  logic [4:0]  dx_rd;
  logic [4:0]  op;
  logic [4:0]  alu;
  logic [4:0]  sh;
  logic [4:0]  rd_addr;
  logic [16:0] imdt;
  logic [26:0] t;
  logic [31:0] pc;
  logic [4:0]  rd_regA;
  logic [4:0]  rd_regB;
  logic        stall;
  logic        dx_bubble;
  logic [15:0] stall_count;

  modport master (
    output instr_in, pc_in, flush, md_busy,
    output dx_opcode, dx_rd,
    input  op, alu, sh, rd_addr, imdt, t, pc,
    input  rd_regA, rd_regB,
    input  stall, dx_bubble, stall_count
  );

  modport slave (
    input  instr_in, pc_in, flush, md_busy,
    input  dx_opcode, dx_rd,
    output op, alu, sh, rd_addr, imdt, t, pc,
    output rd_regA, rd_regB,
    output stall, dx_bubble, stall_count
  );
endinterface

// File: rtl/fd_decode.sv
// fd_decode: FD latch, field decode, read-port select and stall control.
// Load-use interlock is enabled by defining FD_LOADUSE_INTERLOCK_EN.
module fd_decode (
  input  logic       clock,
  input  logic       FD_resetn,
  fd_decode_if.slave bus
);
  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [15:0] count_q;
  logic [4:0]  op;
  logic [4:0]  alu;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        hazard;
  logic        stall;

  logic is_r, is_bne, is_jr, is_addi;
  logic is_blt, is_sw, is_lw, is_bex;

  always_ff @(posedge clock or negedge FD_resetn) begin
    if (!FD_resetn) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (bus.flush) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (!stall) begin
      instr_q <= bus.instr_in;
      pc_q    <= bus.pc_in;
    end
  end

  always_ff @(posedge clock or negedge FD_resetn) begin
    if (!FD_resetn) begin
      count_q <= '0;
    end else if (stall && !bus.flush
                 && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign op      = instr_q[31:27];
  assign is_r    = op == OP_R;
  assign is_bne  = op == OP_BNE;
  assign is_jr   = op == OP_JR;
  assign is_addi = op == OP_ADDI;
  assign is_blt  = op == OP_BLT;
  assign is_sw   = op == OP_SW;
  assign is_lw   = op == OP_LW;
  assign is_bex  = op == OP_BEX;

  // branches compare by subtracting, so they borrow the sub alu code
  always_comb begin
    alu = '0;
    unique case (1'b1)
      is_r:           alu = instr_q[6:2];
      is_bne, is_blt: alu = 5'd1;
      default:        alu = '0;
    endcase
  end

  always_comb begin
    ra = '0;
    unique case (1'b1)
      is_r, is_addi, is_sw,
      is_lw, is_bne, is_blt: ra = instr_q[21:17];
      default:               ra = '0;
    endcase
  end

  always_comb begin
    rb = '0;
    unique case (1'b1)
      is_r:                  rb = instr_q[16:12];
      is_sw, is_bne,
      is_blt, is_jr:         rb = instr_q[26:22];
      is_bex:                rb = 5'd30;
      default:               rb = '0;
    endcase
  end

`ifdef FD_LOADUSE_INTERLOCK_EN
  // r0 reads map to address 0, which never matches a nonzero dx_rd
  assign hazard = bus.dx_opcode == OP_LW
                  && bus.dx_rd != 5'd0
                  && ((ra != 5'd0 && ra == bus.dx_rd)
                   || (rb != 5'd0 && rb == bus.dx_rd));
`else
  logic unused_dx;
  assign unused_dx = ^{bus.dx_opcode, bus.dx_rd};
  assign hazard    = 1'b0;
`endif

  assign stall = bus.md_busy | hazard;

  assign bus.op          = op;
  assign bus.alu         = alu;
  assign bus.sh          = instr_q[11:7];
  assign bus.rd_addr     = instr_q[26:22];
  assign bus.imdt        = instr_q[16:0];
  assign bus.t           = instr_q[26:0];
  assign bus.pc          = pc_q;
  assign bus.rd_regA     = ra;
  assign bus.rd_regB     = rb;
  assign bus.stall       = stall;
  assign bus.dx_bubble   = bus.flush | stall;
  assign bus.stall_count = count_q;
endmodule
